// File: rtl/ahb_mem_arbiter.sv
// Two-port AHB-Lite arbiter sharing one memory slave between S0 and S1.
// Fixed priority S0 > S1, with a starvation limit that forces an S1 grant.
module ahb_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        S0_HSEL,
    input  logic        S0_HREADY,
    input  logic [31:0] S0_HADDR,
    input  logic [1:0]  S0_HTRANS,
    input  logic        S0_HWRITE,
    input  logic [2:0]  S0_HSIZE,
    input  logic [31:0] S0_HWDATA,
    output logic        S0_HREADYOUT,
    output logic [31:0] S0_HRDATA,
    input  logic        S1_HSEL,
    input  logic        S1_HREADY,
    input  logic [31:0] S1_HADDR,
    input  logic [1:0]  S1_HTRANS,
    input  logic        S1_HWRITE,
    input  logic [2:0]  S1_HSIZE,
    input  logic [31:0] S1_HWDATA,
    output logic        S1_HREADYOUT,
    output logic [31:0] S1_HRDATA,
    output logic        M_HSEL,
    output logic        M_HREADY,
    output logic [31:0] M_HADDR,
    output logic [1:0]  M_HTRANS,
    output logic        M_HWRITE,
    output logic [2:0]  M_HSIZE,
    output logic [31:0] M_HWDATA,
    input  logic        M_HREADYOUT,
    input  logic [31:0] M_HRDATA
);

    typedef enum logic [1:0] {
        DP_NONE = 2'd0,
        DP_S0   = 2'd1,
        DP_S1   = 2'd2
    } dp_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic        live0, live1;
    logic        p0_v_q, p0_v_d, p1_v_q, p1_v_d;
    logic [31:0] p0_addr_q, p0_addr_d, p1_addr_q, p1_addr_d;
    logic [1:0]  p0_trans_q, p0_trans_d, p1_trans_q, p1_trans_d;
    logic        p0_wr_q, p0_wr_d, p1_wr_q, p1_wr_d;
    logic [2:0]  p0_size_q, p0_size_d, p1_size_q, p1_size_d;
    logic [3:0]  starve_q, starve_d;
    dp_e         dp_q, dp_d, gnt;

    logic        c0_v, c1_v;
    logic [31:0] c0_addr, c1_addr;
    logic [1:0]  c0_trans, c1_trans;
    logic        c0_wr, c1_wr;
    logic [2:0]  c0_size, c1_size;
    logic        s1_force, s0_win, s1_win;

    assign live0 = S0_HSEL & S0_HREADY & S0_HTRANS[1];
    assign live1 = S1_HSEL & S1_HREADY & S1_HTRANS[1];

    // A port cannot have both pending and live, so pending simply overrides.
    assign c0_v     = p0_v_q | live0;
    assign c0_addr  = p0_v_q ? p0_addr_q  : S0_HADDR;
    assign c0_trans = p0_v_q ? p0_trans_q : S0_HTRANS;
    assign c0_wr    = p0_v_q ? p0_wr_q    : S0_HWRITE;
    assign c0_size  = p0_v_q ? p0_size_q  : S0_HSIZE;
    assign c1_v     = p1_v_q | live1;
    assign c1_addr  = p1_v_q ? p1_addr_q  : S1_HADDR;
    assign c1_trans = p1_v_q ? p1_trans_q : S1_HTRANS;
    assign c1_wr    = p1_v_q ? p1_wr_q    : S1_HWRITE;
    assign c1_size  = p1_v_q ? p1_size_q  : S1_HSIZE;

    assign s1_force = c1_v & (starve_q >= LIMIT);
    assign s0_win   = c0_v & ~s1_force;
    assign s1_win   = c1_v & ~s1_force & ~c0_v;

    always_comb begin
        gnt = DP_NONE;
        if (M_HREADYOUT) begin
            unique case (1'b1)
                s1_force: gnt = DP_S1;
                s0_win:   gnt = DP_S0;
                s1_win:   gnt = DP_S1;
                default:  gnt = DP_NONE;
            endcase
        end
    end

    always_comb begin
        M_HADDR  = 32'd0;
        M_HTRANS = 2'b00;
        M_HWRITE = 1'b0;
        M_HSIZE  = 3'd0;
        unique case (gnt)
            DP_S0: begin
                M_HADDR  = c0_addr;
                M_HTRANS = c0_trans;
                M_HWRITE = c0_wr;
                M_HSIZE  = c0_size;
            end
            DP_S1: begin
                M_HADDR  = c1_addr;
                M_HTRANS = c1_trans;
                M_HWRITE = c1_wr;
                M_HSIZE  = c1_size;
            end
            default: ;
        endcase
    end

    assign M_HSEL   = M_HTRANS[1];
    assign M_HREADY = M_HREADYOUT;

    always_comb begin
        p0_v_d     = p0_v_q;
        p0_addr_d  = p0_addr_q;
        p0_trans_d = p0_trans_q;
        p0_wr_d    = p0_wr_q;
        p0_size_d  = p0_size_q;
        if (p0_v_q && gnt == DP_S0) begin
            p0_v_d = 1'b0;
        end else if (!p0_v_q && live0 && gnt != DP_S0) begin
            p0_v_d     = 1'b1;
            p0_addr_d  = S0_HADDR;
            p0_trans_d = S0_HTRANS;
            p0_wr_d    = S0_HWRITE;
            p0_size_d  = S0_HSIZE;
        end
    end

    always_comb begin
        p1_v_d     = p1_v_q;
        p1_addr_d  = p1_addr_q;
        p1_trans_d = p1_trans_q;
        p1_wr_d    = p1_wr_q;
        p1_size_d  = p1_size_q;
        if (p1_v_q && gnt == DP_S1) begin
            p1_v_d = 1'b0;
        end else if (!p1_v_q && live1 && gnt != DP_S1) begin
            p1_v_d     = 1'b1;
            p1_addr_d  = S1_HADDR;
            p1_trans_d = S1_HTRANS;
            p1_wr_d    = S1_HWRITE;
            p1_size_d  = S1_HSIZE;
        end
    end

    always_comb begin
        starve_d = 4'd0;
        if (p1_v_q && gnt != DP_S1) begin
            starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
        end
    end

    assign dp_d = M_HREADYOUT ? gnt : dp_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            p0_v_q     <= 1'b0;
            p0_addr_q  <= 32'd0;
            p0_trans_q <= 2'b00;
            p0_wr_q    <= 1'b0;
            p0_size_q  <= 3'd0;
            p1_v_q     <= 1'b0;
            p1_addr_q  <= 32'd0;
            p1_trans_q <= 2'b00;
            p1_wr_q    <= 1'b0;
            p1_size_q  <= 3'd0;
            starve_q   <= 4'd0;
            dp_q       <= DP_NONE;
        end else begin
            p0_v_q     <= p0_v_d;
            p0_addr_q  <= p0_addr_d;
            p0_trans_q <= p0_trans_d;
            p0_wr_q    <= p0_wr_d;
            p0_size_q  <= p0_size_d;
            p1_v_q     <= p1_v_d;
            p1_addr_q  <= p1_addr_d;
            p1_trans_q <= p1_trans_d;
            p1_wr_q    <= p1_wr_d;
            p1_size_q  <= p1_size_d;
            starve_q   <= starve_d;
            dp_q       <= dp_d;
        end
    end

    always_comb begin
        M_HWDATA = 32'd0;
        unique case (dp_q)
            DP_S0:   M_HWDATA = S0_HWDATA;
            DP_S1:   M_HWDATA = S1_HWDATA;
            default: M_HWDATA = 32'd0;
        endcase
    end

    assign S0_HREADYOUT = p0_v_q ? 1'b0 :
                          (dp_q == DP_S0) ? M_HREADYOUT : 1'b1;
    assign S1_HREADYOUT = p1_v_q ? 1'b0 :
                          (dp_q == DP_S1) ? M_HREADYOUT : 1'b1;
    assign S0_HRDATA = M_HRDATA;
    assign S1_HRDATA = M_HRDATA;

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed bench for ahb_mem_arbiter with a small byte-lane BRAM model.
// Each master's HREADY is looped back from its HREADYOUT.
module tb_ahb_mem_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        S0_HSEL, S1_HSEL;
    logic        S0_HREADY, S1_HREADY;
    logic [31:0] S0_HADDR, S1_HADDR;
    logic [1:0]  S0_HTRANS, S1_HTRANS;
    logic        S0_HWRITE, S1_HWRITE;
    logic [2:0]  S0_HSIZE, S1_HSIZE;
    logic [31:0] S0_HWDATA, S1_HWDATA;
    logic        S0_HREADYOUT, S1_HREADYOUT;
    logic [31:0] S0_HRDATA, S1_HRDATA;
    logic        M_HSEL, M_HREADY;
    logic [31:0] M_HADDR, M_HWDATA, M_HRDATA;
    logic [1:0]  M_HTRANS;
    logic        M_HWRITE;
    logic [2:0]  M_HSIZE;
    logic        M_HREADYOUT;
    logic        mw;

    int n_chk = 0;
    int n_pass = 0;

    always #5 HCLK = ~HCLK;

    assign S0_HREADY   = S0_HREADYOUT;
    assign S1_HREADY   = S1_HREADYOUT;
    assign M_HREADYOUT = ~mw;

    ahb_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .S0_HSEL(S0_HSEL), .S0_HREADY(S0_HREADY),
        .S0_HADDR(S0_HADDR), .S0_HTRANS(S0_HTRANS),
        .S0_HWRITE(S0_HWRITE), .S0_HSIZE(S0_HSIZE),
        .S0_HWDATA(S0_HWDATA), .S0_HREADYOUT(S0_HREADYOUT),
        .S0_HRDATA(S0_HRDATA),
        .S1_HSEL(S1_HSEL), .S1_HREADY(S1_HREADY),
        .S1_HADDR(S1_HADDR), .S1_HTRANS(S1_HTRANS),
        .S1_HWRITE(S1_HWRITE), .S1_HSIZE(S1_HSIZE),
        .S1_HWDATA(S1_HWDATA), .S1_HREADYOUT(S1_HREADYOUT),
        .S1_HRDATA(S1_HRDATA),
        .M_HSEL(M_HSEL), .M_HREADY(M_HREADY),
        .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS),
        .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
        .M_HWDATA(M_HWDATA), .M_HREADYOUT(M_HREADYOUT),
        .M_HRDATA(M_HRDATA)
    );

    logic [31:0] mem [256];
    logic        dph_v, dph_wr;
    logic [31:0] dph_addr;
    logic [2:0]  dph_size;
    logic [3:0]  be;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        dph_v = 1'b0;
        dph_wr = 1'b0;
        dph_addr = 32'd0;
        dph_size = 3'd0;
    end

    always_comb begin
        be = 4'b1111;
        if (dph_size == 3'd0) be = 4'b0001 << dph_addr[1:0];
        else if (dph_size == 3'd1) be = dph_addr[1] ? 4'b1100 : 4'b0011;
    end

    assign M_HRDATA = mem[dph_addr[9:2]];

    always @(posedge HCLK) begin
        if (M_HREADY) begin
            if (dph_v && dph_wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem[dph_addr[9:2]][8*b +: 8] <= M_HWDATA[8*b +: 8];
            end
            dph_v    <= M_HSEL;
            dph_wr   <= M_HWRITE;
            dph_addr <= M_HADDR;
            dph_size <= M_HSIZE;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic nxt();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle0();
        S0_HSEL = 1'b0; S0_HTRANS = 2'b00; S0_HADDR = 32'd0;
        S0_HWRITE = 1'b0; S0_HSIZE = 3'd0;
    endtask

    task automatic idle1();
        S1_HSEL = 1'b0; S1_HTRANS = 2'b00; S1_HADDR = 32'd0;
        S1_HWRITE = 1'b0; S1_HSIZE = 3'd0;
    endtask

    task automatic s0_req(input logic [31:0] a, input logic w,
                          input logic [2:0] sz);
        S0_HSEL = 1'b1; S0_HTRANS = 2'b10; S0_HADDR = a;
        S0_HWRITE = w; S0_HSIZE = sz;
    endtask

    task automatic s1_req(input logic [31:0] a, input logic w,
                          input logic [2:0] sz);
        S1_HSEL = 1'b1; S1_HTRANS = 2'b10; S1_HADDR = a;
        S1_HWRITE = w; S1_HSIZE = sz;
    endtask

    initial begin
        HRESETn = 1'b0;
        mw = 1'b0;
        idle0(); idle1();
        S0_HWDATA = 32'h55; S1_HWDATA = 32'h66;
        #3;
        chk("rst_s0_rdy", {31'd0, S0_HREADYOUT}, 32'd1);
        chk("rst_s1_rdy", {31'd0, S1_HREADYOUT}, 32'd1);
        chk("rst_trans", {30'd0, M_HTRANS}, 32'd0);
        chk("rst_hsel", {31'd0, M_HSEL}, 32'd0);
        chk("rst_wdata", M_HWDATA, 32'd0);
        nxt(); nxt();
        HRESETn = 1'b1;
        nxt();
        #2;
        chk("idle_trans", {30'd0, M_HTRANS}, 32'd0);
        chk("idle_addr", M_HADDR, 32'd0);
        chk("idle_wdata", M_HWDATA, 32'd0);
        chk("idle_s0_rdy", {31'd0, S0_HREADYOUT}, 32'd1);
        chk("idle_s1_rdy", {31'd0, S1_HREADYOUT}, 32'd1);

        nxt(); s0_req(32'h2000_0010, 1'b1, 3'd2); #2;
        chk("wr_addr", M_HADDR, 32'h2000_0010);
        chk("wr_trans", {30'd0, M_HTRANS}, 32'd2);
        chk("wr_hsel", {31'd0, M_HSEL}, 32'd1);
        chk("wr_s0_rdy0", {31'd0, S0_HREADYOUT}, 32'd1);
        nxt(); idle0(); S0_HWDATA = 32'hDEAD_BEEF; #2;
        chk("wr_wdata", M_HWDATA, 32'hDEAD_BEEF);
        chk("wr_s0_rdy1", {31'd0, S0_HREADYOUT}, 32'd1);
        nxt(); s1_req(32'h2000_0010, 1'b0, 3'd2); #2;
        chk("rd1_addr", M_HADDR, 32'h2000_0010);
        chk("rd1_write", {31'd0, M_HWRITE}, 32'd0);
        nxt(); idle1(); #2;
        chk("rd1_data", S1_HRDATA, 32'hDEAD_BEEF);
        chk("rd1_rdy", {31'd0, S1_HREADYOUT}, 32'd1);

        nxt();
        s0_req(32'h0000_0100, 1'b0, 3'd2);
        s1_req(32'h2000_0004, 1'b1, 3'd2); #2;
        chk("col_addr0", M_HADDR, 32'h0000_0100);
        chk("col_s1_rdy0", {31'd0, S1_HREADYOUT}, 32'd1);
        nxt(); idle0(); idle1(); S1_HWDATA = 32'h1234_5678; #2;
        chk("col_s1_stall", {31'd0, S1_HREADYOUT}, 32'd0);
        chk("col_addr1", M_HADDR, 32'h2000_0004);
        chk("col_write1", {31'd0, M_HWRITE}, 32'd1);
        chk("col_s0_rdy1", {31'd0, S0_HREADYOUT}, 32'd1);
        nxt(); #2;
        chk("col_wdata", M_HWDATA, 32'h1234_5678);
        chk("col_s1_rdy2", {31'd0, S1_HREADYOUT}, 32'd1);
        nxt(); s0_req(32'h2000_0004, 1'b0, 3'd2);
        nxt(); idle0(); #2;
        chk("col_rdback", S0_HRDATA, 32'h1234_5678);

        for (int i = 0; i < 6; i++) begin
            nxt();
            s0_req(32'h200 + 32'(4 * i), 1'b0, 3'd2);
            if (i == 0) s1_req(32'h2000_0040, 1'b0, 3'd2);
            else idle1();
            #2;
            if (i < 5) begin
                chk("stv_s0_addr", M_HADDR, 32'h200 + 32'(4 * i));
                chk("stv_s1_rdy", {31'd0, S1_HREADYOUT},
                    (i == 0) ? 32'd1 : 32'd0);
            end else begin
                chk("stv_s1_gnt", M_HADDR, 32'h2000_0040);
                chk("stv_s1_rdy5", {31'd0, S1_HREADYOUT}, 32'd0);
            end
        end
        nxt(); idle0(); idle1(); #2;
        chk("stv_s0_pend", M_HADDR, 32'h0000_0214);
        chk("stv_s0_stall", {31'd0, S0_HREADYOUT}, 32'd0);
        chk("stv_s1_done", {31'd0, S1_HREADYOUT}, 32'd1);
        chk("stv_cnt_clr", {28'd0, dut.starve_q}, 32'd0);
        nxt(); #2;
        chk("stv_s0_done", {31'd0, S0_HREADYOUT}, 32'd1);

        nxt(); s0_req(32'h2000_0020, 1'b1, 3'd2);
        nxt(); idle0(); S0_HWDATA = 32'hCAFE_F00D; mw = 1'b1;
        s1_req(32'h2000_0010, 1'b0, 3'd2); #2;
        chk("mw_s0_rdy1", {31'd0, S0_HREADYOUT}, 32'd0);
        chk("mw_trans1", {30'd0, M_HTRANS}, 32'd0);
        chk("mw_s1_rdy1", {31'd0, S1_HREADYOUT}, 32'd1);
        nxt(); idle1(); #2;
        chk("mw_s0_rdy2", {31'd0, S0_HREADYOUT}, 32'd0);
        chk("mw_s1_rdy2", {31'd0, S1_HREADYOUT}, 32'd0);
        chk("mw_trans2", {30'd0, M_HTRANS}, 32'd0);
        nxt(); mw = 1'b0; #2;
        chk("mw_s1_addr", M_HADDR, 32'h2000_0010);
        chk("mw_s1_trans", {30'd0, M_HTRANS}, 32'd2);
        chk("mw_s0_done", {31'd0, S0_HREADYOUT}, 32'd1);
        chk("mw_wdata", M_HWDATA, 32'hCAFE_F00D);
        nxt(); #2;
        chk("mw_s1_data", S1_HRDATA, 32'hDEAD_BEEF);
        chk("mw_s1_done", {31'd0, S1_HREADYOUT}, 32'd1);
        nxt(); s0_req(32'h2000_0020, 1'b0, 3'd2);
        nxt(); idle0(); #2;
        chk("mw_rdback", S0_HRDATA, 32'hCAFE_F00D);

        nxt(); s1_req(32'h2000_0003, 1'b1, 3'd0); #2;
        chk("byte_addr", M_HADDR, 32'h2000_0003);
        chk("byte_size", {29'd0, M_HSIZE}, 32'd0);
        nxt(); idle1(); S1_HWDATA = 32'hAA00_0000; #2;
        chk("byte_lane3", {24'd0, M_HWDATA[31:24]}, 32'hAA);
        nxt(); s0_req(32'h2000_0000, 1'b0, 3'd2);
        nxt(); idle0(); #2;
        chk("byte_rdback", S0_HRDATA, 32'hAA00_0000);

        nxt();
        s0_req(32'h0000_0100, 1'b0, 3'd2);
        s1_req(32'h2000_0008, 1'b1, 3'd2);
        S0_HWDATA = 32'h11;
        nxt(); idle0(); idle1(); S1_HWDATA = 32'h22; #2;
        chk("ar_s1_pend", {31'd0, S1_HREADYOUT}, 32'd0);
        #1 HRESETn = 1'b0;
        #1;
        chk("ar_s1_rdy", {31'd0, S1_HREADYOUT}, 32'd1);
        chk("ar_trans", {30'd0, M_HTRANS}, 32'd0);
        chk("ar_hsel", {31'd0, M_HSEL}, 32'd0);
        chk("ar_wdata", M_HWDATA, 32'd0);
        nxt(); HRESETn = 1'b1;
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
